// File: rtl/wb_queue.sv
// wb_queue: in-order write-back queue feeding the register-file write port.
// Merges memory and ALU results, drains one per cycle, exposes hazards.
module wb_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mem_valid,
   input  logic [3:0]    mem_dest,
   input  logic [31:0]   mem_result,
   input  logic          alu_valid,
   input  logic [3:0]    alu_dest,
   input  logic [31:0]   alu_result,
   output logic          in_ready,
   output logic [3:0]    Dest_wb,
   output logic [31:0]   Result_WB,
   output logic          writeBackEn,
   input  logic [3:0]    src1,
   input  logic [3:0]    src2,
   output logic          hazard1,
   output logic          hazard2,
   output logic [31:0]   fwd1,
   output logic [31:0]   fwd2,
   output logic [CW-1:0] count,
   output logic          overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] NOREG = 4'd15;

   typedef struct packed {
      logic [3:0]  dest;
      logic [31:0] data;
   } ent_t;

   ent_t          q [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] idx;
   logic          mem_ok;
   logic          alu_ok;
   logic          push_mem;
   logic          push_alu;
   logic          pop;
   logic          hit1;
   logic          hit2;

   assign mem_ok   = mem_valid && (mem_dest != NOREG);
   assign alu_ok   = alu_valid && (alu_dest != NOREG);
   assign in_ready = count <= CW'(DEPTH - 2);
   assign push_mem = in_ready && mem_ok;
   assign push_alu = in_ready && alu_ok;
   assign pop      = count != '0;

   assign writeBackEn = pop;
   assign Dest_wb     = pop ? q[head].dest : '0;
   assign Result_WB   = pop ? q[head].data : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         head  <= head + AW'(pop);
         tail  <= tail + AW'(push_mem) + AW'(push_alu);
         count <= count + CW'(push_mem) + CW'(push_alu) - CW'(pop);
         if (!in_ready && (mem_ok || alu_ok))
            overflow <= 1'b1;
      end
   end

   // memory result is the older instruction, so it takes the first slot
   always_ff @(posedge clk) begin
      if (push_mem)
         q[tail] <= '{dest: mem_dest, data: mem_result};
      if (push_alu)
         q[tail + AW'(push_mem)] <= '{dest: alu_dest, data: alu_result};
   end

   // walk oldest to youngest so the last match is the youngest value
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      fwd1 = '0;
      fwd2 = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if (CW'(k) < count) begin
            if (q[idx].dest == src1) begin
               hit1 = 1'b1;
               fwd1 = q[idx].data;
            end
            if (q[idx].dest == src2) begin
               hit2 = 1'b1;
               fwd2 = q[idx].data;
            end
         end
      end
   end

   assign hazard1 = hit1
                  || (mem_ok && (mem_dest == src1))
                  || (alu_ok && (alu_dest == src1));
   assign hazard2 = hit2
                  || (mem_ok && (mem_dest == src2))
                  || (alu_ok && (alu_dest == src2));

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: scoreboard bench for the write-back queue.
// Expected writes are queued at enqueue and compared at each negedge write.
module tb_wb_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_valid = 1'b0;
   logic [3:0]  mem_dest = '0;
   logic [31:0] mem_result = '0;
   logic        alu_valid = 1'b0;
   logic [3:0]  alu_dest = '0;
   logic [31:0] alu_result = '0;
   logic        in_ready;
   logic [3:0]  Dest_wb;
   logic [31:0] Result_WB;
   logic        writeBackEn;
   logic [3:0]  src1 = '0;
   logic [3:0]  src2 = '0;
   logic        hazard1;
   logic        hazard2;
   logic [31:0] fwd1;
   logic [31:0] fwd2;
   logic [2:0]  count;
   logic        overflow;

   typedef struct {
      logic [3:0]  d;
      logic [31:0] v;
   } ent_t;

   ent_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   m_count = 0;
   logic m_ovf = 1'b0;

   always #5 clk = ~clk;

   wb_queue #(.DEPTH(4), .CW(3)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_dest(mem_dest),
      .mem_result(mem_result),
      .alu_valid(alu_valid), .alu_dest(alu_dest),
      .alu_result(alu_result),
      .in_ready(in_ready), .Dest_wb(Dest_wb),
      .Result_WB(Result_WB), .writeBackEn(writeBackEn),
      .src1(src1), .src2(src2),
      .hazard1(hazard1), .hazard2(hazard2),
      .fwd1(fwd1), .fwd2(fwd2),
      .count(count), .overflow(overflow)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic void model_fwd(input logic [3:0] s,
                                     output logic h,
                                     output logic [31:0] f);
      h = 1'b0;
      f = '0;
      foreach (sb[i]) begin
         if (sb[i].d == s) begin
            h = 1'b1;
            f = sb[i].v;
         end
      end
      if (mem_valid && mem_dest != 4'd15 && mem_dest == s) h = 1'b1;
      if (alu_valid && alu_dest != 4'd15 && alu_dest == s) h = 1'b1;
   endfunction

   // register-file side: every write must match the oldest expected entry
   always @(negedge clk) begin
      ent_t e;
      if (rst) begin
         chk("wb_en", writeBackEn, sb.size() != 0);
         if (writeBackEn) begin
            if (sb.size() == 0) begin
               chk("spurious_wb", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("wb_dest", Dest_wb, e.d);
               chk("wb_data", Result_WB, e.v);
            end
         end else begin
            chk("idle_dest", Dest_wb, 0);
            chk("idle_data", Result_WB, 0);
         end
      end
   end

   task automatic tick();
      int   pushes;
      bit   rdy;
      logic h;
      logic [31:0] f;
      pushes = 0;
      @(posedge clk);
      rdy = (m_count <= 2);
      if (mem_valid && mem_dest != 4'd15) begin
         if (rdy) begin
            sb.push_back('{mem_dest, mem_result});
            pushes++;
         end else m_ovf = 1'b1;
      end
      if (alu_valid && alu_dest != 4'd15) begin
         if (rdy) begin
            sb.push_back('{alu_dest, alu_result});
            pushes++;
         end else m_ovf = 1'b1;
      end
      m_count = m_count + pushes - ((m_count != 0) ? 1 : 0);
      #1;
      chk("count", count, m_count);
      chk("overflow", overflow, m_ovf);
      chk("in_ready", in_ready, m_count <= 2);
      model_fwd(src1, h, f);
      chk("hazard1", hazard1, h);
      chk("fwd1", fwd1, f);
      model_fwd(src2, h, f);
      chk("hazard2", hazard2, h);
      chk("fwd2", fwd2, f);
   endtask

   task automatic idle_inputs();
      mem_valid = 1'b0;
      alu_valid = 1'b0;
   endtask

   task automatic drain();
      idle_inputs();
      for (int i = 0; i < 8; i++)
         if (m_count != 0) tick();
      chk("drained", count, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_count", count, 0);
      chk("rst_wben", writeBackEn, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_dest", Dest_wb, 0);
      chk("rst_res", Result_WB, 0);
      chk("rst_haz", {hazard1, hazard2}, 0);
      chk("rst_fwd", fwd1 | fwd2, 0);
      #11 rst = 1'b1;

      // dual enqueue: mem then alu, drained on consecutive cycles
      src1 = 4'd3;
      src2 = 4'd4;
      mem_valid = 1'b1; mem_dest = 4'd3; mem_result = 32'hAAAA;
      alu_valid = 1'b1; alu_dest = 4'd4; alu_result = 32'h5555;
      tick();
      chk("dual_cnt2", count, 2);
      idle_inputs();
      tick();
      chk("dual_cnt1", count, 1);
      tick();
      chk("dual_cnt0", count, 0);

      // youngest forwarding, sequential then same-cycle
      src1 = 4'd5;
      src2 = 4'd7;
      alu_valid = 1'b1; alu_dest = 4'd5; alu_result = 32'd1;
      tick();
      alu_result = 32'd2;
      tick();
      idle_inputs();
      #1;
      chk("yf_haz", hazard1, 1);
      chk("yf_fwd", fwd1, 2);
      drain();
      mem_valid = 1'b1; mem_dest = 4'd5; mem_result = 32'd11;
      alu_valid = 1'b1; alu_dest = 4'd5; alu_result = 32'd22;
      tick();
      idle_inputs();
      #1;
      chk("yf2_fwd", fwd1, 22);
      drain();
      #1;
      chk("yf_clr_haz", hazard1, 0);
      chk("yf_clr_fwd", fwd1, 0);

      // incoming-only match raises hazard without forwarding
      alu_valid = 1'b1; alu_dest = 4'd7; alu_result = 32'h77;
      #1;
      chk("inc_haz", hazard2, 1);
      chk("inc_fwd", fwd2, 0);
      tick();
      drain();

      // dest 15 is filtered
      src1 = 4'd15;
      alu_valid = 1'b1; alu_dest = 4'd15; alu_result = 32'h1234;
      #1;
      chk("d15_haz", hazard1, 0);
      tick();
      chk("d15_cnt", count, 0);
      idle_inputs();
      tick();
      chk("d15_wben", writeBackEn, 0);

      // streaming wraps the pointers
      src1 = 4'd6;
      for (int i = 0; i < 10; i++) begin
         alu_valid = 1'b1;
         alu_dest = 4'(i);
         alu_result = 32'(100 + i);
         tick();
         chk("wrap_le1", count <= 1, 1);
      end
      drain();

      // fill until not ready, overflow is sticky
      for (int i = 0; i < 6; i++) begin
         mem_valid = 1'b1; mem_dest = 4'(2 * i);
         mem_result = $urandom;
         alu_valid = 1'b1; alu_dest = 4'(2 * i + 1);
         alu_result = $urandom;
         tick();
      end
      chk("fill_ovf", overflow, 1);
      drain();
      chk("ovf_sticky", overflow, 1);

      // reset mid-drain, asynchronous
      mem_valid = 1'b1; mem_dest = 4'd1; mem_result = 32'h10;
      alu_valid = 1'b1; alu_dest = 4'd2; alu_result = 32'h20;
      tick();
      mem_valid = 1'b0;
      alu_dest = 4'd6; alu_result = 32'h60;
      tick();
      idle_inputs();
      #2 rst = 1'b0;
      #1;
      chk("mr_count", count, 0);
      chk("mr_wben", writeBackEn, 0);
      chk("mr_ovf", overflow, 0);
      chk("mr_haz", hazard1, 0);
      sb.delete();
      m_count = 0;
      m_ovf = 1'b0;
      rst = 1'b1;

      alu_valid = 1'b1; alu_dest = 4'd9; alu_result = 32'h99;
      tick();
      drain();
      chk("sb_empty", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
